// File: rtl/mtm_alu_pkg.sv
// ---------------------------------------------------------------------------
// mtm_alu_pkg
// Shared definitions for the MTM ALU core: operation codes, control-word
// constants for idle and error frames, the result flag layout and the
// core FSM state encoding.
// ---------------------------------------------------------------------------
package mtm_alu_pkg;

    // Operation field carried in CTL[6:4] of a data frame.
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } op_t;

    // Control words. Error frames are {1,D,C,O,D,C,O,parity}.
    localparam logic [7:0] CTL_IDLE = 8'hFF;
    localparam logic [7:0] ERR_DATA = 8'hC9;
    localparam logic [7:0] ERR_CRC  = 8'hA5;
    localparam logic [7:0] ERR_OP   = 8'h93;

    // Result flags, MSB first as they appear in CTL_out[6:3].
    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/mtm_alu_if.sv
// ---------------------------------------------------------------------------
// mtm_alu_if
// Bus between the deserializer/serializer side and the ALU core.
//   A, B      : 32-bit operands, all-ones when idle
//   CTL       : control word (0xFF idle, {0,OP,CRC4} data, bit7=1 error)
//   out_ready : serializer accepts the result
//   C         : result word
//   CTL_out   : {0,flags,CRC3} or an error frame
//   out_valid : result held for the serializer
//   drop_err  : sticky, a frame was lost while a result was pending
// master = deserializer/serializer side, slave = ALU core.
// ---------------------------------------------------------------------------
interface mtm_alu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [7:0]  CTL;
    logic        out_ready;
    logic [31:0] C;
    logic [7:0]  CTL_out;
    logic        out_valid;
    logic        drop_err;

    modport master (
        output A, B, CTL, out_ready,
        input  C, CTL_out, out_valid, drop_err
    );

    modport slave (
        input  A, B, CTL, out_ready,
        output C, CTL_out, out_valid, drop_err
    );
endinterface

// File: rtl/mtm_alu_crc3.sv
// ---------------------------------------------------------------------------
// mtm_alu_crc3
// Combinational CRC3, polynomial x^3+x+1, initial value 000, data consumed
// MSB first.
//   data : 37-bit message {C, 1'b0, flags}
//   crc  : 3-bit remainder
// ---------------------------------------------------------------------------
module mtm_alu_crc3 (
    input  logic [36:0] data,
    output logic [2:0]  crc
);

    // stage[k] is the LFSR contents after k message bits have been shifted in.
    logic [37:0][2:0] stage;

    assign stage[0] = 3'b000;

    for (genvar gi = 0; gi < 37; gi++) begin : g_bit
        logic fb;
        assign fb           = stage[gi][2] ^ data[36-gi];
        assign stage[gi+1]  = {stage[gi][1], stage[gi][0] ^ fb, fb};
    end

    assign crc = stage[37];

endmodule

// File: rtl/mtm_alu.sv
// ---------------------------------------------------------------------------
// mtm_alu_core
// Single-entry ALU stage between the frame deserializer and serializer.
// Inputs are registered once; a frame starts when the registered CTL leaves
// the idle value. The core latches the operands, computes for one cycle and
// holds the result until the serializer accepts it. Frames arriving while a
// result is in flight are dropped and flagged through a sticky drop_err.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mtm_alu_if.slave (A, B, CTL, out_ready -> C, CTL_out,
//           out_valid, drop_err)
// ---------------------------------------------------------------------------
module mtm_alu_core (
    input  logic      clk,
    input  logic      rst_n,
    mtm_alu_if.slave  bus
);
    import mtm_alu_pkg::*;

    state_t      state_reg;

    // Input sample stage; frame-start detection looks at these.
    logic [31:0] a_s_reg;
    logic [31:0] b_s_reg;
    logic [7:0]  ctl_s_reg;
    logic [7:0]  prev_ctl_reg;

    // Operands latched for the frame being executed.
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [7:0]  ctl_reg;

    logic [31:0] c_reg;
    logic [7:0]  ctl_out_reg;
    logic        out_valid_reg;
    logic        drop_err_reg;

    logic        frame_start;
    op_t         op;
    logic [32:0] sum33;
    logic [31:0] alu_c;
    flags_t      flags;
    logic        op_err;
    logic [2:0]  crc;
    logic [31:0] c_next;
    logic [7:0]  ctl_out_next;

    assign frame_start = (ctl_s_reg != CTL_IDLE) && (prev_ctl_reg == CTL_IDLE);
    assign op          = op_t'(ctl_reg[6:4]);

    always_comb begin
        sum33  = '0;
        alu_c  = '0;
        flags  = '0;
        op_err = 1'b0;
        case (op)
            OP_AND: alu_c = b_reg & a_reg;
            OP_OR:  alu_c = b_reg | a_reg;
            OP_ADD: begin
                sum33          = {1'b0, b_reg} + {1'b0, a_reg};
                alu_c          = sum33[31:0];
                flags.carry    = sum33[32];
                // Same-sign operands producing a different-sign result.
                flags.overflow = (a_reg[31] == b_reg[31]) && (alu_c[31] != b_reg[31]);
            end
            OP_SUB: begin
                alu_c          = b_reg - a_reg;
                flags.carry    = (b_reg < a_reg);
                // B - A overflows when signs differ and the result flips B's sign.
                flags.overflow = (a_reg[31] != b_reg[31]) && (alu_c[31] != b_reg[31]);
            end
            default: op_err = 1'b1;
        endcase
        flags.zero     = (alu_c == 32'd0);
        flags.negative = alu_c[31];
    end

    mtm_alu_crc3 u_crc3 (
        .data ({alu_c, 1'b0, flags}),
        .crc  (crc)
    );

    // Upstream error frames pass through untouched and take priority over
    // the operation decode.
    always_comb begin
        c_next       = alu_c;
        ctl_out_next = {1'b0, flags, crc};
        if (ctl_reg[7]) begin
            c_next       = '0;
            ctl_out_next = ctl_reg;
        end else if (op_err) begin
            c_next       = '0;
            ctl_out_next = ERR_OP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            a_s_reg       <= '1;
            b_s_reg       <= '1;
            ctl_s_reg     <= CTL_IDLE;
            prev_ctl_reg  <= CTL_IDLE;
            a_reg         <= '1;
            b_reg         <= '1;
            ctl_reg       <= '1;
            c_reg         <= '0;
            ctl_out_reg   <= CTL_IDLE;
            out_valid_reg <= 1'b0;
            drop_err_reg  <= 1'b0;
        end else begin
            a_s_reg      <= bus.A;
            b_s_reg      <= bus.B;
            ctl_s_reg    <= bus.CTL;
            prev_ctl_reg <= ctl_s_reg;

            case (state_reg)
                ST_IDLE: begin
                    if (frame_start) begin
                        a_reg     <= a_s_reg;
                        b_reg     <= b_s_reg;
                        ctl_reg   <= ctl_s_reg;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    c_reg         <= c_next;
                    ctl_out_reg   <= ctl_out_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_OUT;
                    if (frame_start) begin
                        drop_err_reg <= 1'b1;
                    end
                end
                ST_OUT: begin
                    // Only one result slot: a start here is lost even if
                    // the current result is accepted in the same cycle.
                    if (frame_start) begin
                        drop_err_reg <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.C         = c_reg;
    assign bus.CTL_out   = ctl_out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.drop_err  = drop_err_reg;

endmodule
